// File: rtl/wb_spi_master_p.sv
// Wishbone-slave SPI master: programmable frame width and SCK divider, all CPOL/CPHA modes,
// MSB/LSB-first order, auto/manual chip selects, receive-valid, overrun and level interrupt.
module wb_spi_master_p #(
    parameter int DATA_W  = 8,
    parameter int CS_N    = 4,
    parameter int DIV_W   = 16,
    parameter int RST_DIV = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     wb_adr_i,
    input  logic [31:0]     wb_dat_i,
    output logic [31:0]     wb_dat_o,
    input  logic [3:0]      wb_sel_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    input  logic            wb_we_i,
    output logic            spi_sck,
    output logic            spi_mosi,
    input  logic            spi_miso,
    output logic [CS_N-1:0] spi_cs,
    output logic            irq
);

    localparam int HW = $clog2(2 * DATA_W);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_DIV    = 3'd1;
    localparam logic [2:0] A_TX     = 3'd2;
    localparam logic [2:0] A_RX     = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_CSMAN  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t              r_state;
    logic                r_ack;
    logic [31:0]         r_dat;
    logic                r_cpol, r_cpha, r_lsb, r_auto, r_irq_en;
    logic [2:0]          r_cs_idx;
    logic [DIV_W-1:0]    r_div;
    logic [CS_N-1:0]     r_csman;
    logic                r_s_cpha, r_s_lsb, r_s_auto;
    logic [2:0]          r_s_cs_idx;
    logic [DIV_W-1:0]    r_s_div;
    logic [DIV_W-1:0]    r_cnt;
    logic [HW-1:0]       r_half;
    logic [DATA_W-1:0]   r_tx, r_rx, r_rxdata;
    logic                r_rx_valid, r_overrun;
    logic                r_sck, r_mosi;

    logic                w_req, w_acc, w_wr, w_rd, w_busy;
    logic [2:0]          w_sel;
    logic [31:0]         w_rdata;
    logic [HW-1:0]       w_next_half;
    logic                w_sample;
    logic [CS_N-1:0]     w_onehot;
    logic                w_unused;

    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    assign w_unused = &{1'b0, wb_sel_i, wb_adr_i, wb_dat_i};

    // Register side effects land at the end of the ack cycle, while the master still holds the strobe.
    assign w_req  = wb_cyc_i & wb_stb_i;
    assign w_acc  = r_ack & w_req;
    assign w_wr   = w_acc & wb_we_i;
    assign w_rd   = w_acc & ~wb_we_i;
    assign w_sel  = wb_adr_i[4:2];
    assign w_busy = (r_state != S_IDLE);

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            A_CTRL:   w_rdata = {21'b0, r_cs_idx, 3'b0, r_irq_en, r_auto, r_lsb, r_cpha, r_cpol};
            A_DIV:    w_rdata = 32'(r_div);
            A_RX:     w_rdata = 32'(r_rxdata);
            A_STATUS: w_rdata = {29'b0, r_overrun, r_rx_valid, w_busy};
            A_CSMAN:  w_rdata = 32'(r_csman);
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_lsb    <= 1'b0;
            r_auto   <= 1'b0;
            r_irq_en <= 1'b0;
            r_cs_idx <= '0;
            r_div    <= DIV_W'(RST_DIV);
            r_csman  <= '0;
        end else begin
            r_ack <= w_req & ~r_ack;
            r_dat <= (w_req & ~r_ack) ? w_rdata : '0;
            if (w_wr && w_sel == A_CTRL) begin
                {r_irq_en, r_auto, r_lsb, r_cpha, r_cpol} <= wb_dat_i[4:0];
                r_cs_idx <= wb_dat_i[10:8];
            end
            if (w_wr && w_sel == A_DIV)   r_div   <= wb_dat_i[DIV_W-1:0];
            if (w_wr && w_sel == A_CSMAN) r_csman <= wb_dat_i[CS_N-1:0];
        end
    end

    // Half-period index about to begin; even indices are leading SCK edges.
    assign w_next_half = (r_state == S_LEAD) ? '0 : r_half + HW'(1);
    assign w_sample    = r_s_cpha ^ ~w_next_half[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_s_cpha   <= 1'b0;
            r_s_lsb    <= 1'b0;
            r_s_auto   <= 1'b0;
            r_s_cs_idx <= '0;
            r_s_div    <= '0;
            r_cnt      <= '0;
            r_half     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rxdata   <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            if (w_wr && w_sel == A_STATUS && wb_dat_i[2]) r_overrun <= 1'b0;
            if (w_wr && w_sel == A_TX && w_busy)          r_overrun <= 1'b1;
            if (w_rd && w_sel == A_RX)                    r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sck  <= r_cpol;
                    r_mosi <= 1'b0;
                    if (w_wr && w_sel == A_TX) begin
                        r_state    <= S_LEAD;
                        r_cnt      <= '0;
                        r_s_cpha   <= r_cpha;
                        r_s_lsb    <= r_lsb;
                        r_s_auto   <= r_auto;
                        r_s_cs_idx <= r_cs_idx;
                        r_s_div    <= r_div;
                        r_tx       <= wb_dat_i[DATA_W-1:0];
                        r_mosi     <= r_cpha ? 1'b0 : first_bit(wb_dat_i[DATA_W-1:0], r_lsb);
                    end
                end
                S_LEAD, S_XFER: begin
                    if (r_cnt != r_s_div) begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (r_state == S_XFER && r_half == HALF_LAST) begin
                            r_state <= S_TRAIL;
                        end else begin
                            r_state <= S_XFER;
                            r_half  <= w_next_half;
                            r_sck   <= ~r_sck;
                            if (w_sample) begin
                                r_rx <= r_s_lsb ? {spi_miso, r_rx[DATA_W-1:1]}
                                                : {r_rx[DATA_W-2:0], spi_miso};
                            end else begin
                                r_tx   <= shift_out(r_tx, r_s_lsb);
                                r_mosi <= r_s_cpha ? first_bit(r_tx, r_s_lsb)
                                                   : first_bit(shift_out(r_tx, r_s_lsb), r_s_lsb);
                            end
                        end
                    end
                end
                S_TRAIL: begin
                    if (r_cnt != r_s_div) begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end else begin
                        r_state    <= S_IDLE;
                        r_rxdata   <= r_rx;
                        r_rx_valid <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_sck      <= r_cpol;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int unsigned i = 0; i < CS_N; i++) begin
            if (r_s_cs_idx == 3'(i)) w_onehot[i] = 1'b1;
        end
    end

    assign spi_cs   = ~(r_csman | ((r_s_auto && w_busy) ? w_onehot : '0));
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq      = r_irq_en & r_rx_valid;

endmodule

// File: tb/tb_wb_spi_master_p.sv
// Directed bench for wb_spi_master_p: default 8-bit/4-CS instance plus a 16-bit/2-CS loopback instance.
module tb_wb_spi_master_p;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        stb, we, cyc0, cyc1;
    logic [31:0] dat0, dat1;
    logic        ack0, ack1;
    logic        sck0, mosi0, miso0, irq0;
    logic        sck1, mosi1, irq1;
    logic [3:0]  cs0;
    logic [1:0]  cs1;
    logic        miso_drv, loop_en;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign miso0 = loop_en ? mosi0 : miso_drv;

    wb_spi_master_p dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat0), .wb_sel_i(sel),
        .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_ack_o(ack0), .wb_we_i(we),
        .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0), .spi_cs(cs0), .irq(irq0)
    );

    wb_spi_master_p #(.DATA_W(16), .CS_N(2)) dut16 (
        .clk(clk), .reset(reset),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat1), .wb_sel_i(sel),
        .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_ack_o(ack1), .wb_we_i(we),
        .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(mosi1), .spi_cs(cs1), .irq(irq1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input int d, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd);
        int t;
        t = 0;
        adr = a; wdat = wd; we = wr; stb = 1'b1;
        if (d == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
        do begin
            @(posedge clk); #1; t++;
        end while (((d == 0) ? ack0 : ack1) !== 1'b1 && t < 16);
        rd = (d == 0) ? dat0 : dat1;
        check("wb_ack", 32'((d == 0) ? ack0 : ack1), 32'd1);
        @(posedge clk); #1;
        stb = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input int d, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_cycle(d, 1'b1, a, wd, dummy);
    endtask

    task automatic wb_read_chk(input int d, input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_cycle(d, 1'b0, a, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    // Starts an 8-bit transfer and checks SCK, CS and MOSI every cycle against a timing model,
    // presenting MISO bit j one half-period before its sample edge.
    task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [7:0] mp,
                            input logic cpol, input logic cpha, input logic lsb, input int div,
                            input logic [3:0] cs_act, input logic [3:0] cs_idle);
        int hp, total, tog, ns, sck_bad, cs_bad, mosi_bad;
        logic exp_bit;
        hp = div + 1;
        total = 18 * hp;
        sck_bad = 0; cs_bad = 0; mosi_bad = 0;
        wb_write(0, 32'h08, {24'h0, tx});
        for (int n = 0; n <= total; n++) begin
            tog = (n / hp > 16) ? 16 : n / hp;
            if (sck0 !== (cpol ^ tog[0])) sck_bad++;
            if (cs0 !== ((n < total) ? cs_act : cs_idle)) cs_bad++;
            if (n == total && mosi0 !== 1'b0) mosi_bad++;
            for (int j = 0; j < 8; j++) begin
                ns = cpha ? hp * (2 * j + 2) : hp * (2 * j + 1);
                exp_bit = lsb ? tx[j] : tx[7 - j];
                if (n == ns - 1 && mosi0 !== exp_bit) mosi_bad++;
                if (n == ns - hp) miso_drv = mp[7 - j];
            end
            if (n < total) begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_sck_errs"}, sck_bad, 0);
        check({tag, "_cs_errs"}, cs_bad, 0);
        check({tag, "_mosi_errs"}, mosi_bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  pat;
        logic [31:0] rd;
        int cs_bad, polls;

        reset = 1'b1; adr = '0; wdat = '0; sel = 4'hF; stb = 1'b0; we = 1'b0;
        cyc0 = 1'b0; cyc1 = 1'b0; miso_drv = 1'b0; loop_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pins", {sck0, mosi0, cs0, ack0, irq0}, 8'h3C);
        check("reset_dat", dat0, 32'h0);
        reset = 1'b0;

        wb_read_chk(0, "ctrl_rst", 32'h00, 32'h0);
        wb_read_chk(0, "div_rst", 32'h04, 32'h4);
        wb_read_chk(0, "rx_rst", 32'h0C, 32'h0);
        wb_read_chk(0, "status_rst", 32'h10, 32'h0);
        wb_read_chk(0, "csman_rst", 32'h14, 32'h0);
        wb_write(0, 32'h18, 32'hFFFF_FFFF);
        wb_read_chk(0, "unmapped", 32'h18, 32'h0);
        wb_write(0, 32'h00, 32'h71F);
        wb_read_chk(0, "ctrl_rw", 32'h00, 32'h71F);
        wb_write(0, 32'h04, 32'h1234);
        wb_read_chk(0, "div_rw", 32'h04, 32'h1234);
        wb_write(0, 32'h14, 32'hFF);
        wb_read_chk(0, "csman_mask", 32'h14, 32'hF);
        wb_write(0, 32'h14, 32'h0);
        wb_write(0, 32'h04, 32'h4);
        wb_write(0, 32'h00, 32'h0);

        pat = '0;
        adr = 32'h0; we = 1'b0; stb = 1'b1; cyc0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pat = {pat[2:0], ack0};
        end
        stb = 1'b0; cyc0 = 1'b0;
        check("ack_held_strobe", pat, 4'b1010);

        wb_write(0, 32'h00, 32'h08);
        run_xfer("mode0", 8'h69, 8'hC9, 1'b0, 1'b0, 1'b0, 4, 4'b1110, 4'b1111);
        wb_read_chk(0, "mode0_status", 32'h10, 32'h2);
        check("mode0_irq_off", irq0, 1'b0);
        wb_read_chk(0, "mode0_rx", 32'h0C, 32'hC9);
        wb_read_chk(0, "mode0_rxv_clr", 32'h10, 32'h0);

        wb_write(0, 32'h00, 32'h0A);
        run_xfer("mode1", 8'h69, 8'hC9, 1'b0, 1'b1, 1'b0, 4, 4'b1110, 4'b1111);
        wb_read_chk(0, "mode1_rx", 32'h0C, 32'hC9);

        wb_write(0, 32'h00, 32'h09);
        @(posedge clk); #1;
        check("mode2_idle_sck", sck0, 1'b1);
        run_xfer("mode2", 8'h69, 8'hC9, 1'b1, 1'b0, 1'b0, 4, 4'b1110, 4'b1111);
        wb_read_chk(0, "mode2_rx", 32'h0C, 32'hC9);

        wb_write(0, 32'h00, 32'h1B);
        @(posedge clk); #1;
        check("mode3_idle_sck", sck0, 1'b1);
        run_xfer("mode3", 8'h69, 8'hC9, 1'b1, 1'b1, 1'b0, 4, 4'b1110, 4'b1111);
        check("mode3_irq_on", irq0, 1'b1);
        wb_read_chk(0, "mode3_rx", 32'h0C, 32'hC9);
        check("mode3_irq_clr", irq0, 1'b0);

        wb_write(0, 32'h00, 32'h0C);
        run_xfer("lsb", 8'h69, 8'hC9, 1'b0, 1'b0, 1'b1, 4, 4'b1110, 4'b1111);
        wb_read_chk(0, "lsb_rx", 32'h0C, 32'h93);

        wb_write(0, 32'h00, 32'h08);
        loop_en = 1'b1;
        wb_write(0, 32'h08, 32'h69);
        wb_write(0, 32'h08, 32'hAA);
        wb_read_chk(0, "ovr_status_busy", 32'h10, 32'h5);
        polls = 0;
        do begin
            wb_cycle(0, 1'b0, 32'h10, 32'h0, rd);
            polls++;
        end while (rd[0] !== 1'b0 && polls < 60);
        check("ovr_status_done", rd, 32'h6);
        wb_read_chk(0, "ovr_rx", 32'h0C, 32'h69);
        wb_write(0, 32'h10, 32'h4);
        wb_read_chk(0, "ovr_cleared", 32'h10, 32'h0);
        loop_en = 1'b0;

        wb_write(0, 32'h00, 32'h00);
        wb_write(0, 32'h14, 32'h6);
        check("csman_idle", cs0, 4'b1001);
        run_xfer("csman", 8'h69, 8'hC9, 1'b0, 1'b0, 1'b0, 4, 4'b1001, 4'b1001);
        wb_read_chk(0, "csman_rx", 32'h0C, 32'hC9);
        wb_write(0, 32'h00, 32'h308);
        run_xfer("cs_idx3", 8'h69, 8'hC9, 1'b0, 1'b0, 1'b0, 4, 4'b0001, 4'b1001);
        wb_read_chk(0, "cs_idx3_rx", 32'h0C, 32'hC9);
        wb_write(0, 32'h00, 32'h508);
        run_xfer("cs_idx5", 8'h69, 8'hC9, 1'b0, 1'b0, 1'b0, 4, 4'b1001, 4'b1001);
        wb_read_chk(0, "cs_idx5_status", 32'h10, 32'h2);
        wb_write(0, 32'h14, 32'h0);

        wb_write(0, 32'h04, 32'h0);
        wb_write(0, 32'h00, 32'h1B);
        check("irq_pre_reset", irq0, 1'b1);
        wb_write(0, 32'h08, 32'h69);
        repeat (8) @(posedge clk);
        #2;
        check("mid_xfer_sck", sck0, 1'b1);
        check("mid_xfer_cs", cs0, 4'b1110);
        reset = 1'b1;
        #1;
        check("async_reset_pins", {sck0, mosi0, cs0, ack0, irq0}, 8'h3C);
        check("async_reset_dat", dat0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        wb_read_chk(0, "post_reset_div", 32'h04, 32'h4);
        wb_read_chk(0, "post_reset_ctrl", 32'h00, 32'h0);
        wb_read_chk(0, "post_reset_status", 32'h10, 32'h0);
        wb_write(0, 32'h04, 32'h0);
        wb_write(0, 32'h00, 32'h08);
        run_xfer("div0", 8'h69, 8'hC9, 1'b0, 1'b0, 1'b0, 0, 4'b1110, 4'b1111);
        wb_read_chk(0, "div0_rx", 32'h0C, 32'hC9);

        wb_write(1, 32'h00, 32'h08);
        wb_write(1, 32'h08, 32'hBEEF);
        cs_bad = 0;
        for (int n = 0; n <= 170; n++) begin
            if (cs1 !== ((n < 170) ? 2'b10 : 2'b11)) cs_bad++;
            if (n < 170) begin
                @(posedge clk); #1;
            end
        end
        check("w16_cs_errs", cs_bad, 0);
        wb_read_chk(1, "w16_status", 32'h10, 32'h2);
        wb_read_chk(1, "w16_rx", 32'h0C, 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_spi_master_p.md
# wb_spi_master_p

Parametrised Wishbone-slave SPI master: next generation of the single-mode, fixed-8-bit `wb_spi` peripheral. It adds:
- programmable frame width and SCK divider;
- all four CPOL/CPHA modes and MSB/LSB-first order;
- multiple chip selects with automatic or manual control;
- a receive-valid flag, overrun detection and an interrupt output.

It sits on the SoC Wishbone bus beside the other peripherals and drives the RFID reader's SPI pins.

## Interface
- `DATA_W`, 8: SPI frame width in bits, 4..32.
- `CS_N`, 4: number of chip-select outputs, 1..8.
- `DIV_W`, 16: divider register width.
- `RST_DIV`, 4: divider value after reset.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `wb_adr_i` in 32: byte address; only bits [4:2] are decoded.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_sel_i` in 4: ignored; all accesses are full-word.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_ack_o` out 1: acknowledge.
- `wb_we_i` in 1: 1 = write, 0 = read.
- `spi_sck` out 1: SPI clock.
- `spi_mosi` out 1: master out.
- `spi_miso` in 1: master in.
- `spi_cs` out `CS_N`: chip selects, active-low.
- `irq` out 1: level interrupt, equal to `irq_en & rx_valid`.

## Operation
Register map (offset: field, reset value):
- 0x00 CTRL:
  - [0] cpol, [1] cpha, [2] lsb_first, [3] auto_cs, [4] irq_en;
  - [10:8] cs_idx, index of the device selected in auto mode;
  - reset value 0.
- 0x04 DIV: half-period of SCK in clk cycles, minus 1; reset `RST_DIV`.
- 0x08 TXDATA (write): low `DATA_W` bits.
  - Idle: the write latches the data and starts a transfer.
  - Busy: the data is dropped and `overrun` is set.
- 0x0C RXDATA (read): last received frame, zero-extended; reset 0. A read clears `rx_valid`.
- 0x10 STATUS:
  - [0] busy, [1] rx_valid, [2] overrun;
  - writing 1 to bit 2 clears `overrun`; all other bits are read-only.
- 0x14 CSMAN: [`CS_N`-1:0] manual select mask, 1 = asserted; reset 0.

Other rules:
- Unmapped offsets read 0 and ignore writes, but are still acked.
- CTRL and DIV are snapshotted when a transfer starts; writes to them during a transfer affect only the next transfer.
- Output `spi_cs = ~(csman | (auto_active ? onehot(cs_idx) : 0))`.
  - `auto_active` is high in states LEAD, XFER and TRAIL when `auto_cs` = 1.
  - A `cs_idx` ≥ `CS_N` selects no device.
- FSM states: IDLE → LEAD → XFER → TRAIL → IDLE. Each LEAD, TRAIL and XFER half-period lasts DIV+1 clk cycles.
  - IDLE: SCK = cpol. A TXDATA write moves to LEAD.
  - LEAD: CS setup. The first MOSI bit is driven if cpha = 0.
  - XFER: 2·`DATA_W` SCK half-periods; SCK toggles at the start of each half-period.
    - cpha = 0: MISO is sampled on leading edges; MOSI shifts on trailing edges.
    - cpha = 1: MOSI shifts on leading edges; MISO is sampled on trailing edges.
  - TRAIL: CS hold. SCK rests at cpol.
  - On leaving TRAIL, RXDATA is loaded and `rx_valid` is set.
- Bit order:
  - lsb_first = 0: bit `DATA_W`-1 is sent first, and received bits shift in at bit 0.
  - lsb_first = 1: the mirror image.
- `spi_mosi` is 0 whenever the FSM is in IDLE.

## Timing
- Wishbone ack is registered: `wb_ack_o` rises one cycle after `wb_cyc_i & wb_stb_i` and lasts exactly one cycle.
  - It is low in the cycle after an ack, even if the strobe is held, so a held strobe gives an ack every other cycle.
  - Register writes and read side effects take place in the ack cycle.
  - `wb_dat_o` is valid in the ack cycle.
- busy rises on the clock after the TXDATA ack and falls on the clock where the FSM returns to IDLE.
- Transfer length is (2·`DATA_W`+2)·(DIV+1) clk cycles.
  - Example: `DATA_W` = 8, DIV = 4 gives 90 cycles.
- Same-cycle events:
  - Completion and an RXDATA read: the new data is loaded and `rx_valid` stays 1.
  - An overrun-clear write and a new overrun: `overrun` stays 1.
- Reset asserted at any time, including mid-transfer, acts immediately (asynchronous):
  - FSM returns to IDLE; all registers take their reset values;
  - `spi_sck` = 0, `spi_mosi` = 0, `spi_cs` = all ones;
  - `wb_ack_o` = 0, `wb_dat_o` = 0, `irq` = 0.

## Test plan
- Mode 0, MSB-first, DIV = 4, auto_cs, cs_idx = 0. Write TXDATA = 0x69 while MISO presents 1,1,0,0,1,0,0,1.
  - MOSI shows 0,1,1,0,1,0,0,1 on the 8 rising edges.
  - RXDATA = 0xC9.
  - `spi_cs` = 4'b1110 for 90 cycles.
  - `irq` = 1 only if irq_en = 1.
- Modes 1, 2 and 3, and lsb_first = 1, with the same stimulus.
  - SCK idle level equals cpol in each mode.
  - Sample edges follow the CPHA rule.
  - With lsb_first = 1, RXDATA = 0x93.
- Write TXDATA = 0xAA while busy.
  - The transfer in progress is unaffected.
  - STATUS = 3'b101 during the transfer.
  - After writing 0x4 to STATUS, overrun = 0.
- Manual CS: set CSMAN = 4'b0110 with auto_cs = 0.
  - `spi_cs` = 4'b1001 before, during and after a transfer.
  - Setting auto_cs = 1 with cs_idx = 3 gives `spi_cs` = 4'b0001 during the transfer.
- Assert reset halfway through a DIV = 0 transfer.
  - All outputs reach their reset values immediately.
  - A new transfer after reset completes correctly in 18 cycles.
- `DATA_W` = 16, `CS_N` = 2 build. Write TXDATA = 0xBEEF with MISO looped back to MOSI.
  - RXDATA = 0xBEEF after 34·(DIV+1) cycles.
